// File: rtl/au_addsub_arbiter.sv
// au_addsub_arbiter: round-robin share of one AU_addsub among NREQ requesters.
// Optional macro AU_ADDSUB_ARBITER_OVF_EN adds a registered signed-overflow flag out_ovf.

module AU_addsub #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_s
);
  logic [WIDTH-1:0] w_be, w_g, w_p, w_gg, w_pp;
  assign w_be = i_b ^ {WIDTH{i_sub}};
  assign w_g  = i_a & w_be;
  assign w_p  = i_a ^ w_be;
  // Prefix carry network; the carry-in is folded into bit 0 so w_gg[i] is the carry out of bit i.
  always_comb begin
    w_gg = w_g;
    w_pp = w_p;
    w_gg[0] = w_g[0] | (w_p[0] & i_sub);
    if (ARCH == 2) begin
      for (int i = 1; i < WIDTH; i++) w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-1]);
    end else begin
      for (int d = 1; d < WIDTH; d = d * 2)
        for (int i = WIDTH - 1; i >= 0; i--)
          if (ARCH == 0 && i >= d) begin
            w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
            w_pp[i] = w_pp[i] & w_pp[i-d];
          end else if (ARCH == 1 && (i & d) != 0) begin
            w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[(i & ~(2*d-1)) + d - 1]);
            w_pp[i] = w_pp[i] & w_pp[(i & ~(2*d-1)) + d - 1];
          end
    end
  end
  assign o_s = w_p ^ WIDTH'({w_gg, i_sub});
endmodule

module au_addsub_arbiter #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0,
  parameter int NREQ  = 4,
  localparam int IDW  = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_add_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_s,
`ifdef AU_ADDSUB_ARBITER_OVF_EN
  output logic                  out_ovf,
`endif
  output logic [IDW-1:0]        out_id
);
  logic             r_valid;
  logic [WIDTH-1:0] r_s;
  logic [IDW-1:0]   r_id, r_ptr, w_win;
  logic             w_found, w_grant, w_sub;
  logic [WIDTH-1:0] w_a, w_b, w_s;
  // Pick the first valid requester searching upward from the pointer, wrapping at NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    for (int k = 0; k < NREQ; k++)
      if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win = IDW'((int'(r_ptr) + k) % NREQ);
      end
  end
  assign w_grant   = w_found && (!r_valid || out_ready);
  assign req_ready = w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;
  // Steer the winner's operands into the single shared adder.
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_sub = 1'b0;
    for (int k = 0; k < NREQ; k++)
      if (IDW'(k) == w_win) begin
        w_a = req_a[k*WIDTH +: WIDTH];
        w_b = req_b[k*WIDTH +: WIDTH];
        w_sub = req_add_sub[k];
      end
  end
  AU_addsub #(.WIDTH(WIDTH), .ARCH(ARCH)) u_addsub (
    .i_a(w_a),
    .i_b(w_b),
    .i_sub(w_sub),
    .o_s(w_s)
  );
  // Result register: reset wins, a new accept replaces the old result, a bare drain clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_s <= '0;
      r_id <= '0;
      r_ptr <= '0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_s <= w_s;
      r_id <= w_win;
      r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
`ifdef AU_ADDSUB_ARBITER_OVF_EN
  logic r_ovf, w_ovf;
  assign w_ovf = (w_a[WIDTH-1] == (w_b[WIDTH-1] ^ w_sub)) && (w_s[WIDTH-1] != w_a[WIDTH-1]);
  // Overflow flag travels with the result it describes.
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (w_grant) r_ovf <= w_ovf;
  end
  assign out_ovf = r_ovf;
`endif
  assign out_valid = r_valid;
  assign out_s     = r_s;
  assign out_id    = r_id;
endmodule
